// File: rtl/alu_sequencer.sv
// Sequential front end for the 16-bit Hmmm ALU. It accepts one operation per request
// handshake and holds the operands stable for a programmable settle time. It then strobes
// the ALU for one cycle and registers the result and flags into a response held until
// the consumer takes it. Divide/modulo by zero is trapped without strobing the ALU.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] alu_tmp1,
  output logic [15:0] alu_tmp2,
  output logic [2:0]  alu_op,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_sign,
  output logic        rsp_divzero
);

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StResp} state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       div_trap;

  // Ready only in IDLE, and held low while reset is asserted.
  assign req_ready = (state_q == StIdle) && !reset;

  // Division or modulo by zero never reaches the ALU strobe.
  assign div_trap = ((req_op == 3'b011) || (req_op == 3'b100)) && (req_b == 16'h0000);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      alu_tmp1    <= 16'h0000;
      alu_tmp2    <= 16'h0000;
      alu_op      <= 3'b000;
      alu_enable  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_zero    <= 1'b0;
      rsp_carry   <= 1'b0;
      rsp_sign    <= 1'b0;
      rsp_divzero <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            alu_tmp1 <= req_a;
            alu_tmp2 <= req_b;
            alu_op   <= req_op;
            if (div_trap) begin
              state_q     <= StResp;
              rsp_valid   <= 1'b1;
              rsp_result  <= 16'h0000;
              rsp_zero    <= 1'b1;
              rsp_carry   <= 1'b0;
              rsp_sign    <= 1'b0;
              rsp_divzero <= 1'b1;
            end else begin
              state_q <= StLoad;
              cnt_q   <= SettleInit;
            end
          end
        end
        StLoad: begin
          if (cnt_q == 4'd0) begin
            state_q    <= StExec;
            alu_enable <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StExec: begin
          alu_enable  <= 1'b0;
          rsp_result  <= alu_result;
          rsp_zero    <= alu_zero;
          rsp_carry   <= alu_carry;
          rsp_sign    <= alu_sign;
          rsp_divzero <= 1'b0;
          rsp_valid   <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          // Response data is left in place after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a default-settle instance and a SETTLE_CYCLES=3
// instance, each driving a small behavioural ALU that only drives its bus when enabled.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid3;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_ready;

  logic        req_ready, alu_enable, alu_zero, alu_carry, alu_sign;
  logic [15:0] alu_tmp1, alu_tmp2, alu_result, rsp_result;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_zero, rsp_carry, rsp_sign, rsp_divzero;

  logic        req_ready3, alu_enable3, alu_zero3, alu_carry3, alu_sign3;
  logic [15:0] alu_tmp13, alu_tmp23, alu_result3, rsp_result3;
  logic [2:0]  alu_op3;
  logic        rsp_valid3, rsp_zero3, rsp_carry3, rsp_sign3, rsp_divzero3;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  // Counts cycles with the ALU strobe high on the default instance.
  always @(posedge clk) if (alu_enable === 1'b1) en_cnt <= en_cnt + 1;

  // Behavioural ALU: {result, zero, carry, sign}; bus is all zero when not enabled.
  function automatic logic [18:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic en);
    logic signed [31:0] r;
    logic [15:0]        res;
    logic               c;
    r = 0;
    case (op)
      3'b000: r = $signed(a) + $signed(b);
      3'b001: r = $signed(a) - $signed(b);
      3'b010: r = $signed(a) * $signed(b);
      3'b011: r = (b == 16'h0) ? 0 : $signed(a) / $signed(b);
      3'b100: r = (b == 16'h0) ? 0 : $signed(a) % $signed(b);
      default: r = 0;
    endcase
    res = r[15:0];
    c   = (r != {{16{res[15]}}, res});
    if (!en) return 19'h0;
    return {res, (res == 16'h0), c, res[15]};
  endfunction

  assign {alu_result, alu_zero, alu_carry, alu_sign} =
    alu_model(alu_op, alu_tmp1, alu_tmp2, alu_enable);
  assign {alu_result3, alu_zero3, alu_carry3, alu_sign3} =
    alu_model(alu_op3, alu_tmp13, alu_tmp23, alu_enable3);

  alu_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign),
    .rsp_divzero(rsp_divzero)
  );

  alu_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_tmp1(alu_tmp13), .alu_tmp2(alu_tmp23), .alu_op(alu_op3), .alu_enable(alu_enable3),
    .alu_result(alu_result3), .alu_zero(alu_zero3), .alu_carry(alu_carry3),
    .alu_sign(alu_sign3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_carry(rsp_carry3), .rsp_sign(rsp_sign3),
    .rsp_divzero(rsp_divzero3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the default instance for exactly one accepting edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  int en_base;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0;
    req_op = 3'b000; req_a = 16'h0; req_b = 16'h0;
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_tmp1", alu_tmp1, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_divzero", rsp_divzero, 0);
    reset = 1'b0;
    step();
    chk("idle_req_ready", req_ready, 1);

    // Add overflow
    en_base = en_cnt;
    issue(3'b000, 16'h7FFF, 16'h0001);
    chk("add_tmp1", alu_tmp1, 16'h7FFF);
    chk("add_tmp2", alu_tmp2, 16'h0001);
    chk("add_load_en", alu_enable, 0);
    chk("add_load_ready", req_ready, 0);
    step();
    chk("add_exec_en", alu_enable, 1);
    chk("add_exec_valid", rsp_valid, 0);
    step();
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 16'h8000);
    chk("add_flags_zcsd", {rsp_zero, rsp_carry, rsp_sign, rsp_divzero}, 4'b0110);
    chk("add_en_cycles", en_cnt - en_base, 1);
    release_rsp();
    chk("add_done_valid", rsp_valid, 0);
    chk("add_result_kept", rsp_result, 16'h8000);
    chk("add_back_idle", req_ready, 1);

    // Subtract to zero
    issue(3'b001, 16'd5, 16'd5);
    step(); step();
    chk("sub_valid", rsp_valid, 1);
    chk("sub_result", rsp_result, 16'h0000);
    chk("sub_flags_zcsd", {rsp_zero, rsp_carry, rsp_sign, rsp_divzero}, 4'b1000);
    release_rsp();

    // Divide and modulo by zero
    en_base = en_cnt;
    issue(3'b011, 16'd100, 16'd0);
    chk("div0_valid", rsp_valid, 1);
    chk("div0_result", rsp_result, 16'h0000);
    chk("div0_flags_zcsd", {rsp_zero, rsp_carry, rsp_sign, rsp_divzero}, 4'b1001);
    chk("div0_tmp1", alu_tmp1, 16'd100);
    release_rsp();
    issue(3'b100, 16'd9, 16'd0);
    chk("mod0_valid", rsp_valid, 1);
    chk("mod0_flags_zcsd", {rsp_zero, rsp_carry, rsp_sign, rsp_divzero}, 4'b1001);
    chk("mod0_op", alu_op, 3'b100);
    step();
    chk("div0_no_enable", en_cnt - en_base, 0);
    release_rsp();

    // Multiply with backpressure; next request waits on req_valid
    issue(3'b010, 16'hFFFD, 16'd7);
    step(); step();
    req_op = 3'b000; req_a = 16'd1; req_b = 16'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 16'hFFEB);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_divzero", rsp_divzero, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_not_yet_tmp1", alu_tmp1, 16'hFFFD);
    step();
    req_valid = 1'b0;
    chk("bp_next_tmp1", alu_tmp1, 16'd1);
    chk("bp_next_op", alu_op, 3'b000);
    step(); step();
    chk("bp_next_result", rsp_result, 16'd3);
    release_rsp();

    // Reset during EXEC
    issue(3'b000, 16'd2, 16'd3);
    step();
    chk("rst_exec_en", alu_enable, 1);
    reset = 1'b1;
    step();
    chk("rstx_outs", {alu_tmp1, alu_tmp2, alu_op, alu_enable, rsp_valid}, 0);
    chk("rstx_rsp", {rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_divzero}, 0);
    chk("rstx_req_ready", req_ready, 0);
    reset = 1'b0;
    step();
    chk("rstx_after_ready", req_ready, 1);
    chk("rstx_after_valid", rsp_valid, 0);

    // SETTLE_CYCLES = 3, signed divide
    req_op = 3'b011; req_a = 16'hFFF9; req_b = 16'd2; req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s3_load_en", alu_enable3, 0);
      chk("s3_load_valid", rsp_valid3, 0);
      step();
    end
    chk("s3_exec_en", alu_enable3, 1);
    chk("s3_exec_valid", rsp_valid3, 0);
    step();
    chk("s3_valid", rsp_valid3, 1);
    chk("s3_en_off", alu_enable3, 0);
    chk("s3_result", rsp_result3, 16'hFFFD);
    chk("s3_flags_zcsd", {rsp_zero3, rsp_carry3, rsp_sign3, rsp_divzero3}, 4'b0010);
    release_rsp();
    chk("s3_done", rsp_valid3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequential front end that drives the 16-bit Hmmm ALU's operand/op/enable interface and captures its combinational result and flags into registers. Sits between the control unit and the ALU. The control unit issues one operation per request on a valid/ready handshake and receives a registered response on a second valid/ready handshake. It holds operands stable for a programmable settle time so the combinational multiply/divide paths settle before capture. It traps divide/modulo by zero without strobing the ALU.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held with alu_enable low before the execute cycle; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, others yield 0
req_a  input  16  signed operand A
req_b  input  16  signed operand B
alu_tmp1  output  16  operand A to ALU
alu_tmp2  output  16  operand B to ALU
alu_op  output  3  opcode to ALU
alu_enable  output  1  ALU result-bus enable
alu_result  input  16  ALU result
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry/overflow flag
alu_sign  input  1  ALU sign flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  16  captured result
rsp_zero  output  1  captured zero flag
rsp_carry  output  1  captured carry flag
rsp_sign  output  1  captured sign flag
rsp_divzero  output  1  op was div/mod with B == 0

Behaviour:
- FSM states: IDLE, LOAD, EXEC, RESP. Settle counter is 4 bits.
- Reset (synchronous, on the edge where reset is high):
  - state goes to IDLE and the counter clears.
  - alu_tmp1, alu_tmp2, alu_op, rsp_result clear to 0.
  - All flag outputs, alu_enable and rsp_valid clear to 0.
  - req_ready = (state==IDLE) && !reset, so it is 0 while reset is high.
  - Reset in any state aborts the operation; no response is produced.
- IDLE:
  - req_ready=1.
  - On edge with req_valid: latch req_a/req_b/req_op into alu_tmp1/alu_tmp2/alu_op.
  - If op is 011 or 100 and req_b==0, go to RESP with rsp_result=0, rsp_zero=1, rsp_carry=0, rsp_sign=0, rsp_divzero=1. alu_enable never asserts.
  - Otherwise go to LOAD with the counter loaded to SETTLE_CYCLES-1.
- LOAD:
  - req_ready=0, alu_enable=0, operands held.
  - Counter decrements each edge; go to EXEC on the edge where the counter is 0.
- EXEC:
  - alu_enable=1 for exactly one cycle.
  - At the closing edge, capture alu_result/zero/carry/sign into rsp_*, clear rsp_divzero, go to RESP.
- RESP:
  - rsp_valid=1, all rsp_* held stable, req_ready=0.
  - On edge with rsp_ready, go to IDLE and clear rsp_valid. rsp_* data retains its last value.
  - A new request cannot be accepted in the same cycle as the response handshake (minimum one IDLE cycle).
- Operand outputs alu_tmp1/alu_tmp2/alu_op change only on an IDLE accept; they are stable through LOAD, EXEC and RESP.
- Latency from accepting edge:
  - rsp_valid is first high after SETTLE_CYCLES+1 further edges (default 2).
  - Divide-by-zero trap: rsp_valid is high immediately after the accepting edge.
- Opcodes 101-111 pass to the ALU unmodified; the captured result is 0 with rsp_zero=1.
- No arithmetic is performed in this block; widths pass through unchanged.

Test Plan:
- Add overflow: op=000, A=0x7FFF, B=0x0001 -> after 2 edges rsp_valid=1, rsp_result=0x8000, carry=1, sign=1, zero=0, divzero=0. alu_enable is high exactly one cycle.
- Sub to zero: op=001, A=5, B=5 -> rsp_result=0, zero=1, carry=0, sign=0.
- Divide by zero: op=011, A=100, B=0 -> rsp_valid high right after accept, result=0, zero=1, divzero=1, alu_enable never high. Repeat with op=100.
- Backpressure: op=010, A=-3, B=7 with rsp_ready low for 5 cycles -> rsp_result=0xFFEB held all 5 cycles and req_ready=0 with req_valid high. After rsp_ready=1, one IDLE cycle, then the second request is accepted.
- SETTLE_CYCLES=3: op=011, A=-7, B=2 -> alu_enable low for 3 cycles then high 1 cycle. rsp_valid high after 4 edges, rsp_result=0xFFFD.
- Reset mid-EXEC: assert reset during EXEC -> next edge all outputs 0, state IDLE, no rsp_valid. req_ready=1 the cycle after reset deasserts.
